cook_time_entry: RTL
====================

# cook_time_entry

Keypad front end for the oven's cook timer. Accepts a microwave-style sequence of decimal digits interpreted as MM:SS, converts it to a seconds count and validates it. On success it locks the value onto `cookTime` and raises `timeinputdone`, which the downstream oven timer consumes together with `preheated`. The value stays locked until the user clears it.

## Interface
- `MAX_SECONDS`, default 3599: largest accepted cook time in seconds. The downstream timer works modulo 3600.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `digit_valid` in 1: one-cycle strobe; `digit` is valid.
- `digit` in 4: keypad digit, BCD.
- `enter` in 1: one-cycle strobe; request to commit the entered time.
- `clear` in 1: one-cycle strobe; discard entry or release the locked time.
- `cookTime` out 13: committed cook time in seconds, 0..MAX_SECONDS.
- `timeinputdone` out 1: level; high while `cookTime` is locked.
- `digits` out 16: four BCD display digits {M1,M0,S1,S0}.
- `error` out 1: one-cycle pulse on a rejected digit or rejected entry.

## Operation
- The state machine has three states: ENTRY, CHECK, LOCKED.
- Reset state is ENTRY. On reset, `cookTime`=0, `timeinputdone`=0, `digits`=0, `error`=0, and the digit count is 0.
- **ENTRY** state; input priority is `clear` > `enter` > `digit_valid`.
  - `clear`: `digits` and the count go to 0.
  - `enter` with count=0: `error` pulses and the block stays in ENTRY.
  - `enter` with count>0: go to CHECK.
  - `digit_valid` with `digit`≤9: `digits` shifts left by one nibble and the new digit enters S0.
    - The count increments and saturates at 4.
    - A fifth and later digit drops M1. For example, 1,2,3,4,5 gives 23:45.
  - `digit_valid` with `digit`>9: the digit is ignored and `error` pulses.
- **CHECK** state lasts exactly one cycle.
  - total = (M1·10+M0)·60 + (S1·10+S0). This is computed in at least 13 bits; the maximum is 99·60+99 = 6039.
  - Seconds digits 60..99 are legal. For example, 0:90 gives 90.
  - If 1 ≤ total ≤ MAX_SECONDS: `cookTime`←total, `timeinputdone`←1, go to LOCKED.
  - Otherwise: `error` pulses, `digits` and the count clear, `cookTime` is unchanged (0), go to ENTRY.
  - `clear`, `enter` and `digit_valid` are ignored during CHECK.
- **LOCKED** state.
  - `digit_valid` and `enter` are ignored.
  - `clear`: `timeinputdone`←0, `cookTime`←0, `digits` and the count clear, go to ENTRY.
- `error` is never high for two consecutive cycles from a single event.

## Timing
- A digit sampled at edge N appears on `digits` after edge N.
- `enter` sampled at edge N puts the block in CHECK after edge N.
- Edge N+1 then produces one of:
  - `timeinputdone`=1 with `cookTime` valid in the same cycle (2-edge latency from `enter`), or
  - `error`=1 for exactly that one cycle.
- `cookTime` only changes in these cases:
  - it updates together with `timeinputdone` rising, so it is stable whenever `timeinputdone`=1;
  - it returns to 0 on the edge at which `timeinputdone` falls.
- `clear` sampled at edge N in LOCKED makes `timeinputdone`=0 after edge N. The downstream `done` consequently drops on its next clock.
- Asserting `rst_n` low at any time, in any state, forces all outputs to their reset values immediately. This includes mid-entry and mid-CHECK.
- After `rst_n` deasserts, strobes are accepted from the first rising edge.

## Test plan
1. Digits 1,3,0 then `enter`.
   - `digits`=0x0130.
   - 2 edges after `enter`: `cookTime`=90, `timeinputdone`=1, `error`=0.
2. Digits 5,9,9,9 then `enter` (5999 s).
   - `error` pulses for 1 cycle, `timeinputdone` stays 0, `digits` returns to 0.
   - Repeat with 5,9,5,9: `cookTime`=3599.
3. Digits 1,2,3,4,5 then `enter`: `digits`=0x2345, `cookTime`=1425. Separately, `enter` with no digits: `error` pulse, state stays ENTRY.
4. `digit`=0xA strobe: `error` pulse and `digits` unchanged. Then digits 0,0,9,0 → `cookTime`=90.
5. In LOCKED, strobe `digit_valid` and `enter`: no change. Then `clear`: after 1 edge, `timeinputdone`=0 and `cookTime`=0. New entry 2,0,0 → `cookTime`=120.
6. Pull `rst_n` low mid-entry after 3 digits, and again during the CHECK cycle.
   - All outputs go to 0 asynchronously, and `error` is not pulsed.
   - After release, entry 4,5 → `cookTime`=45.

Source files
------------

// File: rtl/cook_time_entry.sv
// cook_time_entry: keypad front end for the oven cook timer.
// Collects microwave-style MM:SS digit entry, converts it to seconds,
// validates the range and locks the result for the downstream timer.
module cook_time_entry #(
   parameter int unsigned MAX_SECONDS = 3599
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        digit_valid,
   input  logic [3:0]  digit,
   input  logic        enter,
   input  logic        clear,
   output logic [12:0] cookTime,
   output logic        timeinputdone,
   output logic [15:0] digits,
   output logic        error
);

   typedef enum logic [1:0] {
      ST_ENTRY  = 2'd0,
      ST_CHECK  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam logic [12:0] MAX_SEC_C = 13'(MAX_SECONDS);
   localparam logic [2:0]  COUNT_MAX = 3'd4;

   state_t      state_q, state_d;
   logic [15:0] digits_q, digits_d;
   logic [2:0]  count_q, count_d;
   logic [12:0] cook_time_q, cook_time_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic [12:0] total;

   // Seconds value of the displayed digits; worst case 99:99 = 6039 fits in 13 bits.
   always_comb begin
      total = 13'(digits_q[15:12]) * 13'd600
            + 13'(digits_q[11:8])  * 13'd60
            + 13'(digits_q[7:4])   * 13'd10
            + 13'(digits_q[3:0]);
   end

   // Next-state and datapath updates for the ENTRY / CHECK / LOCKED sequence.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_d     = state_q;
      digits_d    = digits_q;
      count_d     = count_q;
      cook_time_d = cook_time_q;
      done_d      = done_q;
      error_d     = 1'b0;

      unique case (state_q)
         ST_ENTRY: begin
            if (clear) begin
               digits_d = 16'h0000;
               count_d  = 3'd0;
            end else if (enter) begin
               if (count_q == 3'd0) begin
                  error_d = 1'b1;
               end else begin
                  state_d = ST_CHECK;
               end
            end else if (digit_valid) begin
               if (digit <= 4'd9) begin
                  // Shifting left drops M1 once more than four digits arrive.
                  digits_d = {digits_q[11:0], digit};
                  if (count_q != COUNT_MAX) begin
                     count_d = count_q + 3'd1;
                  end
               end else begin
                  error_d = 1'b1;
               end
            end
         end

         ST_CHECK: begin
            // All strobes are ignored here; the decision takes exactly one cycle.
            if ((total >= 13'd1) && (total <= MAX_SEC_C)) begin
               cook_time_d = total;
               done_d      = 1'b1;
               state_d     = ST_LOCKED;
            end else begin
               error_d  = 1'b1;
               digits_d = 16'h0000;
               count_d  = 3'd0;
               state_d  = ST_ENTRY;
            end
         end

         ST_LOCKED: begin
            if (clear) begin
               cook_time_d = 13'd0;
               done_d      = 1'b0;
               digits_d    = 16'h0000;
               count_d     = 3'd0;
               state_d     = ST_ENTRY;
            end
         end

         default: begin
            state_d = ST_ENTRY;
         end
      endcase
   end

   // State and output registers with asynchronous clear to the idle values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ENTRY;
         digits_q    <= 16'h0000;
         count_q     <= 3'd0;
         cook_time_q <= 13'd0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         digits_q    <= digits_d;
         count_q     <= count_d;
         cook_time_q <= cook_time_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign cookTime      = cook_time_q;
   assign timeinputdone = done_q;
   assign digits        = digits_q;
   assign error         = error_q;

endmodule
